// File: rtl/adrdec_pkg.sv
// Shared types and constants for the programmable address decoder (adrdec_multi).
package adrdec_pkg;

    typedef struct packed {
        logic [3:0] size_mask;
        logic       x;
        logic       w;
        logic       r;
        logic       supported;
    } region_attr_t;

    typedef enum logic [1:0] {
        CFG_BASE   = 2'd0,
        CFG_RANGE  = 2'd1,
        CFG_ATTR   = 2'd2,
        CFG_HITCNT = 2'd3
    } cfg_field_e;

    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_32 = 2'd2;
    localparam logic [1:0] SIZE_64 = 2'd3;

endpackage

// File: rtl/adrdec_region.sv
// One decode region: base/range/attribute registers, combinational hit and,
// with ADRDEC_PERF_EN defined, a saturating hit counter.
module adrdec_region
    import adrdec_pkg::*;
#(
    parameter int unsigned PA_BITS  = 56,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we_base_i,
    input  logic                we_range_i,
    input  logic                we_attr_i,
    input  logic [PA_BITS-1:0]  wdata_i,
    input  logic [PA_BITS-1:0]  req_adr_i,
    input  logic [1:0]          req_size_i,
    input  logic [2:0]          req_access_i,
`ifdef ADRDEC_PERF_EN
    input  logic                cnt_clr_i,
    input  logic                cnt_inc_i,
`endif
    output logic [PA_BITS-1:0]  base_o,
    output logic [PA_BITS-1:0]  range_o,
    output region_attr_t        attr_o,
    output logic [CNT_BITS-1:0] cnt_o,
    output logic                hit_o
);

    logic [PA_BITS-1:0] base_q;
    logic [PA_BITS-1:0] range_q;
    region_attr_t       attr_q;
    logic               adr_match;
    logic               acc_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            range_q <= '0;
            attr_q  <= '0;
        end else begin
            if (we_base_i)  base_q  <= wdata_i;
            if (we_range_i) range_q <= wdata_i;
            if (we_attr_i)  attr_q  <= region_attr_t'(wdata_i[7:0]);
        end
    end

    // Range bits are don't-care address bits; every other bit must equal Base.
    assign adr_match = &((req_adr_i ~^ base_q) | range_q);
    assign acc_ok    = |(req_access_i & {attr_q.x, attr_q.w, attr_q.r});
    assign hit_o     = adr_match & attr_q.supported & acc_ok & attr_q.size_mask[req_size_i];

    assign base_o  = base_q;
    assign range_o = range_q;
    assign attr_o  = attr_q;

`ifdef ADRDEC_PERF_EN
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: rtl/adrdec_multi.sv
// N-region programmable physical-address decoder with a 1-entry registered response.
// Optional per-region hit counters are built when ADRDEC_PERF_EN is defined.
module adrdec_multi
    import adrdec_pkg::*;
#(
    parameter int unsigned PA_BITS  = 56,
    parameter int unsigned NREGIONS = 8,
    parameter int unsigned CNT_BITS = 16,
    localparam int unsigned IDX_W   = (NREGIONS > 1) ? $clog2(NREGIONS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [PA_BITS-1:0]  ReqAdr,
    input  logic [1:0]          ReqSize,
    input  logic [2:0]          ReqAccess,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [NREGIONS-1:0] RspSel,
    output logic [IDX_W-1:0]    RspIdx,
    output logic                RspErr,
    input  logic                CfgWe,
    input  logic [IDX_W-1:0]    CfgIdx,
    input  logic [1:0]          CfgField,
    input  logic [PA_BITS-1:0]  CfgWData,
    output logic [PA_BITS-1:0]  CfgRData,
    input  logic                CfgLock
);

    logic [PA_BITS-1:0]  base_a  [NREGIONS];
    logic [PA_BITS-1:0]  range_a [NREGIONS];
    region_attr_t        attr_a  [NREGIONS];
    logic [CNT_BITS-1:0] cnt_a   [NREGIONS];
    logic [NREGIONS-1:0] hit;

    logic                rsp_valid_q;
    logic [NREGIONS-1:0] sel_q;
    logic [IDX_W-1:0]    idx_q;
    logic                err_q;
    logic                lock_q;

    logic [NREGIONS-1:0] sel_d;
    logic [IDX_W-1:0]    idx_d;
    logic                err_d;
    logic                accept;
    logic                idx_ok;
    logic                cfg_wr;
    cfg_field_e          field;

    assign field    = cfg_field_e'(CfgField);
    assign idx_ok   = (32'(CfgIdx) < NREGIONS);
    // Uses the pre-update lock, so a write coinciding with CfgLock still lands.
    assign cfg_wr   = CfgWe & ~lock_q & idx_ok;
    assign ReqReady = ~rsp_valid_q | RspReady;
    assign accept   = ReqValid & ReqReady;

    for (genvar g = 0; g < NREGIONS; g++) begin : g_region
        logic sel_idx;
        assign sel_idx = (CfgIdx == IDX_W'(g));

        adrdec_region #(
            .PA_BITS  (PA_BITS),
            .CNT_BITS (CNT_BITS)
        ) u_region (
            .clk          (clk),
            .reset_n      (reset_n),
            .we_base_i    (cfg_wr & sel_idx & (field == CFG_BASE)),
            .we_range_i   (cfg_wr & sel_idx & (field == CFG_RANGE)),
            .we_attr_i    (cfg_wr & sel_idx & (field == CFG_ATTR)),
            .wdata_i      (CfgWData),
            .req_adr_i    (ReqAdr),
            .req_size_i   (ReqSize),
            .req_access_i (ReqAccess),
`ifdef ADRDEC_PERF_EN
            .cnt_clr_i    (CfgWe & idx_ok & sel_idx & (field == CFG_HITCNT)),
            .cnt_inc_i    (accept & sel_d[g]),
`endif
            .base_o       (base_a[g]),
            .range_o      (range_a[g]),
            .attr_o       (attr_a[g]),
            .cnt_o        (cnt_a[g]),
            .hit_o        (hit[g])
        );
    end

    always_comb begin
        sel_d = '0;
        idx_d = '0;
        err_d = 1'b1;
        for (int unsigned i = 0; i < NREGIONS; i++) begin
            if (hit[i] && err_d) begin
                sel_d[i] = 1'b1;
                idx_d    = IDX_W'(i);
                err_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            sel_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end else if (RspReady) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lock_q <= 1'b0;
        else          lock_q <= lock_q | CfgLock;
    end

    always_comb begin
        CfgRData = '0;
        if (idx_ok) begin
            case (field)
                CFG_BASE:   CfgRData = base_a[CfgIdx];
                CFG_RANGE:  CfgRData = range_a[CfgIdx];
                CFG_ATTR:   CfgRData = PA_BITS'(attr_a[CfgIdx]);
                CFG_HITCNT: CfgRData = PA_BITS'(cnt_a[CfgIdx]);
                default:    CfgRData = '0;
            endcase
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspSel   = sel_q;
    assign RspIdx   = idx_q;
    assign RspErr   = err_q;

endmodule

// File: tb/tb_adrdec_multi.sv
// Directed self-checking bench for adrdec_multi; counter checks follow ADRDEC_PERF_EN.
module tb_adrdec_multi;

    localparam int unsigned PA = 56;
    localparam int unsigned NR = 8;
    localparam int unsigned CB = 4;
    localparam int unsigned IW = 3;

    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ReqValid;
    logic          ReqReady;
    logic [PA-1:0] ReqAdr;
    logic [1:0]    ReqSize;
    logic [2:0]    ReqAccess;
    logic          RspValid;
    logic          RspReady;
    logic [NR-1:0] RspSel;
    logic [IW-1:0] RspIdx;
    logic          RspErr;
    logic          CfgWe;
    logic [IW-1:0] CfgIdx;
    logic [1:0]    CfgField;
    logic [PA-1:0] CfgWData;
    logic [PA-1:0] CfgRData;
    logic          CfgLock;

    int errors = 0;
    int checks = 0;

    adrdec_multi #(
        .PA_BITS  (PA),
        .NREGIONS (NR),
        .CNT_BITS (CB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqAdr    (ReqAdr),
        .ReqSize   (ReqSize),
        .ReqAccess (ReqAccess),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspSel    (RspSel),
        .RspIdx    (RspIdx),
        .RspErr    (RspErr),
        .CfgWe     (CfgWe),
        .CfgIdx    (CfgIdx),
        .CfgField  (CfgField),
        .CfgWData  (CfgWData),
        .CfgRData  (CfgRData),
        .CfgLock   (CfgLock)
    );

    always #5 clk = ~clk;

    task automatic cfg_wr(input logic [IW-1:0] idx, input logic [1:0] fld, input logic [PA-1:0] data);
        CfgWe = 1'b1; CfgIdx = idx; CfgField = fld; CfgWData = data;
        @(posedge clk); #1;
        CfgWe = 1'b0;
    endtask

    task automatic do_req(input logic [PA-1:0] adr, input logic [1:0] size, input logic [2:0] acc);
        ReqValid = 1'b1; ReqAdr = adr; ReqSize = size; ReqAccess = acc;
        @(posedge clk); #1;
        ReqValid = 1'b0;
    endtask

    task automatic set_rd(input logic [IW-1:0] idx, input logic [1:0] fld);
        CfgIdx = idx; CfgField = fld; #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ReqValid = 1'b0; ReqAdr = '0; ReqSize = '0; ReqAccess = '0;
        RspReady = 1'b1; CfgWe = 1'b0; CfgIdx = '0; CfgField = '0; CfgWData = '0; CfgLock = 1'b0;
        #12;
        checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", RspValid); end
        checks++; if (RspSel !== '0 || RspIdx !== '0 || RspErr !== 1'b0) begin
            errors++; $display("FAIL reset_rsp sel=%h idx=%0d err=%b exp 0/0/0", RspSel, RspIdx, RspErr); end
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ReqReady); end
        set_rd(3'd0, 2'd2);
        checks++; if (CfgRData !== '0) begin errors++; $display("FAIL reset_attr got=%h exp=0", CfgRData); end
        reset_n = 1'b1;
        do_req(56'h1000, 2'd2, ACC_R);
        checks++; if (RspValid !== 1'b1 || RspErr !== 1'b1 || RspSel !== '0 || RspIdx !== '0) begin
            errors++; $display("FAIL no_region v=%b err=%b sel=%h idx=%0d exp 1/1/00/0", RspValid, RspErr, RspSel, RspIdx); end
    endtask

    task automatic test_decode();
        cfg_wr(3'd0, 2'd0, 56'h0200_0000);
        cfg_wr(3'd0, 2'd1, 56'hFFFF);
        cfg_wr(3'd0, 2'd2, 56'hAB_CDF3);
        set_rd(3'd0, 2'd2);
        checks++; if (CfgRData !== 56'hF3) begin errors++; $display("FAIL attr_upper got=%h exp=f3", CfgRData); end
        do_req(56'h0200_1234, 2'd3, ACC_R);
        checks++; if (RspErr !== 1'b0 || RspSel !== 8'h01 || RspIdx !== 3'd0) begin
            errors++; $display("FAIL r0_read err=%b sel=%h idx=%0d exp 0/01/0", RspErr, RspSel, RspIdx); end
        do_req(56'h0200_1234, 2'd3, ACC_W);
        checks++; if (RspErr !== 1'b1 || RspSel !== '0) begin
            errors++; $display("FAIL r0_write err=%b sel=%h exp 1/00", RspErr, RspSel); end
        // size mask 0011: sizes 0 and 1 legal only
        cfg_wr(3'd0, 2'd2, 56'h33);
        do_req(56'h0200_1234, 2'd2, ACC_R);
        checks++; if (RspErr !== 1'b1) begin errors++; $display("FAIL size_illegal err=%b exp=1", RspErr); end
        do_req(56'h0200_1234, 2'd1, ACC_R);
        checks++; if (RspErr !== 1'b0 || RspSel !== 8'h01) begin
            errors++; $display("FAIL size_legal err=%b sel=%h exp 0/01", RspErr, RspSel); end
        cfg_wr(3'd0, 2'd2, 56'hF3);
        // Request in the same cycle as a disabling write decodes with old attributes
        CfgWe = 1'b1; CfgIdx = 3'd0; CfgField = 2'd2; CfgWData = '0;
        do_req(56'h0200_0000, 2'd0, ACC_R);
        CfgWe = 1'b0;
        checks++; if (RspErr !== 1'b0 || RspSel !== 8'h01) begin
            errors++; $display("FAIL same_cycle_cfg err=%b sel=%h exp 0/01", RspErr, RspSel); end
        do_req(56'h0200_0000, 2'd0, ACC_R);
        checks++; if (RspErr !== 1'b1) begin errors++; $display("FAIL after_disable err=%b exp=1", RspErr); end
        cfg_wr(3'd0, 2'd2, 56'hF3);
    endtask

    task automatic test_priority();
        cfg_wr(3'd1, 2'd0, 56'h8000_0000);
        cfg_wr(3'd1, 2'd1, 56'h0FFF_FFFF);
        cfg_wr(3'd1, 2'd2, 56'hF3);
        cfg_wr(3'd2, 2'd0, 56'h8000_0000);
        cfg_wr(3'd2, 2'd1, 56'hFFF);
        cfg_wr(3'd2, 2'd2, 56'hF3);
        do_req(56'h8000_0010, 2'd2, ACC_R);
        checks++; if (RspErr !== 1'b0 || RspSel !== 8'h02 || RspIdx !== 3'd1) begin
            errors++; $display("FAIL priority err=%b sel=%h idx=%0d exp 0/02/1", RspErr, RspSel, RspIdx); end
        do_req(56'h9000_0000, 2'd2, ACC_R);
        checks++; if (RspErr !== 1'b1 || RspSel !== '0 || RspIdx !== '0) begin
            errors++; $display("FAIL outside_range err=%b sel=%h idx=%0d exp 1/00/0", RspErr, RspSel, RspIdx); end
    endtask

    task automatic test_back_to_back();
        logic [PA-1:0] adr   [4];
        logic [NR-1:0] e_sel [4];
        logic [IW-1:0] e_idx [4];
        logic          e_err [4];
        adr[0] = 56'h0200_0000; e_sel[0] = 8'h01; e_idx[0] = 3'd0; e_err[0] = 1'b0;
        adr[1] = 56'h8000_0010; e_sel[1] = 8'h02; e_idx[1] = 3'd1; e_err[1] = 1'b0;
        adr[2] = 56'h9000_0000; e_sel[2] = 8'h00; e_idx[2] = 3'd0; e_err[2] = 1'b1;
        adr[3] = 56'h8000_0ABC; e_sel[3] = 8'h02; e_idx[3] = 3'd1; e_err[3] = 1'b0;
        RspReady = 1'b1; ReqValid = 1'b1; ReqSize = 2'd2; ReqAccess = ACC_R; ReqAdr = adr[0];
        @(posedge clk); #1;
        RspReady = 1'b0; ReqAdr = adr[1]; #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, ReqReady); end
            checks++; if (RspValid !== 1'b1 || RspSel !== e_sel[0] || RspIdx !== e_idx[0] || RspErr !== e_err[0]) begin
                errors++; $display("FAIL stall_hold cyc=%0d v=%b sel=%h idx=%0d err=%b", c, RspValid, RspSel, RspIdx, RspErr); end
            @(posedge clk); #1;
        end
        RspReady = 1'b1;
        for (int i = 1; i < 4; i++) begin
            ReqAdr = adr[i];
            @(posedge clk); #1;
            checks++; if (RspValid !== 1'b1 || RspSel !== e_sel[i] || RspIdx !== e_idx[i] || RspErr !== e_err[i]) begin
                errors++; $display("FAIL stream rsp=%0d v=%b sel=%h idx=%0d err=%b exp sel=%h idx=%0d err=%b",
                    i, RspValid, RspSel, RspIdx, RspErr, e_sel[i], e_idx[i], e_err[i]); end
        end
        ReqValid = 1'b0;
        @(posedge clk); #1;
        checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", RspValid); end
    endtask

    task automatic test_lock_reset();
        // Write and lock at the same edge: the write still lands
        CfgLock = 1'b1;
        cfg_wr(3'd1, 2'd0, 56'hA000_0000);
        CfgLock = 1'b0;
        set_rd(3'd1, 2'd0);
        checks++; if (CfgRData !== 56'hA000_0000) begin errors++; $display("FAIL lock_same_cycle got=%h exp=a0000000", CfgRData); end
        cfg_wr(3'd0, 2'd0, 56'h0);
        set_rd(3'd0, 2'd0);
        checks++; if (CfgRData !== 56'h0200_0000) begin errors++; $display("FAIL locked_write got=%h exp=2000000", CfgRData); end
        RspReady = 1'b0;
        do_req(56'h0200_0000, 2'd0, ACC_R);
        checks++; if (RspValid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", RspValid); end
        #2 reset_n = 1'b0; #1;
        checks++; if (RspValid !== 1'b0 || RspSel !== '0) begin
            errors++; $display("FAIL async_reset v=%b sel=%h exp 0/00", RspValid, RspSel); end
        @(negedge clk); reset_n = 1'b1; RspReady = 1'b1;
        set_rd(3'd0, 2'd0);
        checks++; if (CfgRData !== '0) begin errors++; $display("FAIL reset_base got=%h exp=0", CfgRData); end
        cfg_wr(3'd0, 2'd0, 56'h1234_0000);
        set_rd(3'd0, 2'd0);
        checks++; if (CfgRData !== 56'h1234_0000) begin errors++; $display("FAIL lock_cleared got=%h exp=12340000", CfgRData); end
    endtask

    task automatic test_perf();
        cfg_wr(3'd0, 2'd0, 56'h0200_0000);
        cfg_wr(3'd0, 2'd1, 56'hFFFF);
        cfg_wr(3'd0, 2'd2, 56'hF3);
`ifdef ADRDEC_PERF_EN
        for (int i = 0; i < 3; i++) do_req(56'h0200_0100, 2'd0, ACC_R);
        set_rd(3'd0, 2'd3);
        checks++; if (CfgRData !== 56'd3) begin errors++; $display("FAIL cnt_three got=%0d exp=3", CfgRData); end
        CfgLock = 1'b1; @(posedge clk); #1; CfgLock = 1'b0;
        cfg_wr(3'd0, 2'd3, '0);
        set_rd(3'd0, 2'd3);
        checks++; if (CfgRData !== '0) begin errors++; $display("FAIL cnt_clear_locked got=%0d exp=0", CfgRData); end
        for (int i = 0; i < 16; i++) do_req(56'h0200_0100, 2'd0, ACC_R);
        set_rd(3'd0, 2'd3);
        checks++; if (CfgRData !== 56'd15) begin errors++; $display("FAIL cnt_saturate got=%0d exp=15", CfgRData); end
        do_req(56'h0200_0100, 2'd0, ACC_R);
        set_rd(3'd0, 2'd3);
        checks++; if (CfgRData !== 56'd15) begin errors++; $display("FAIL cnt_hold got=%0d exp=15", CfgRData); end
        CfgWe = 1'b1; CfgIdx = 3'd0; CfgField = 2'd3; CfgWData = '0;
        do_req(56'h0200_0100, 2'd0, ACC_R);
        CfgWe = 1'b0;
        set_rd(3'd0, 2'd3);
        checks++; if (CfgRData !== '0) begin errors++; $display("FAIL clear_wins got=%0d exp=0", CfgRData); end
`else
        for (int i = 0; i < 3; i++) do_req(56'h0200_0100, 2'd0, ACC_R);
        cfg_wr(3'd0, 2'd3, 56'h5);
        set_rd(3'd0, 2'd3);
        checks++; if (CfgRData !== '0) begin errors++; $display("FAIL field3_zero got=%h exp=0", CfgRData); end
        set_rd(3'd0, 2'd2);
        checks++; if (CfgRData !== 56'hF3) begin errors++; $display("FAIL field3_no_side got=%h exp=f3", CfgRData); end
`endif
    endtask

    initial begin
        test_reset();
        test_decode();
        test_priority();
        test_back_to_back();
        test_lock_reset();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
